noc_vc_input_port: RTL and testbench

Parametrised router input port holding incoming flits in per-virtual-channel FIFOs, sitting between the link receiver and the switch allocator. Each virtual channel (VC) is an independent first-word-fall-through queue with its own head-flit output, occupancy count and credit-return pulse, so the upstream router can track buffer space. Illegal accesses are flagged by a sticky error bit rather than corrupting state. Storage is internal registers, with no vendor FIFO.

---
 rtl/noc_vc_input_port.sv | 109 ++++++++++
 tb/tb_noc_vc_input_port.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_input_port.sv
// Router input port with one first-word-fall-through FIFO per virtual channel.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   data_i, vc_i  incoming flit and its target VC
//   write_en      push request for data_i into VC vc_i
//   shift         per-VC pop request
//   data_o        head flit of each VC (zero when that VC is empty)
//   read_valid_o  VC holds at least one flit
//   full_o        VC holds DEPTH flits
//   count_o       per-VC occupancy, packed like data_o
//   credit_o      one-cycle pulse per accepted pop
//   error_o       sticky flag for rejected pushes and pops
module noc_vc_input_port #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned NUM_VC = 2,
  localparam int unsigned VCW   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         data_i,
  input  logic [VCW-1:0]           vc_i,
  input  logic                     write_en,
  input  logic [NUM_VC-1:0]        shift,
  output logic [NUM_VC*WIDTH-1:0]  data_o,
  output logic [NUM_VC-1:0]        read_valid_o,
  output logic [NUM_VC-1:0]        full_o,
  output logic [NUM_VC*CW-1:0]     count_o,
  output logic [NUM_VC-1:0]        credit_o,
  output logic                     error_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic              vc_legal;
  logic [NUM_VC-1:0] push_ok;
  logic [NUM_VC-1:0] pop_ok;
  logic [NUM_VC-1:0] valid;
  logic [NUM_VC-1:0] full;
  logic              err_q;
  logic              err_event;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Compare one bit wider so a power-of-two NUM_VC does not alias to zero.
  assign vc_legal = ({1'b0, vc_i} < (VCW + 1)'(NUM_VC));

  // A rejected push or a pop of an empty VC raises the sticky error.
  assign err_event = (write_en & ~(|push_ok)) | (|(shift & ~valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_event;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             credit_q;
    logic [WIDTH-1:0] mem [DEPTH];

    assign valid[v]  = (cnt != '0);
    assign full[v]   = (cnt == CW'(DEPTH));
    assign pop_ok[v] = shift[v] & valid[v];
    // A full VC still accepts a push when the same VC pops in this cycle.
    assign push_ok[v] = write_en & vc_legal & (vc_i == VCW'(v)) & (~full[v] | shift[v]);

    // Pointer, occupancy and credit state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        cnt      <= '0;
        credit_q <= 1'b0;
      end else begin
        credit_q <= pop_ok[v];
        if (push_ok[v]) wr_ptr <= ptr_inc(wr_ptr);
        if (pop_ok[v])  rd_ptr <= ptr_inc(rd_ptr);
        if (push_ok[v] && !pop_ok[v]) begin
          cnt <= cnt + CW'(1);
        end else if (pop_ok[v] && !push_ok[v]) begin
          cnt <= cnt - CW'(1);
        end
      end
    end

    // Flit storage; contents are don't-care until written, masked by valid.
    always_ff @(posedge clk) begin
      if (push_ok[v]) mem[wr_ptr] <= data_i;
    end

    assign data_o[v*WIDTH +: WIDTH] = valid[v] ? mem[rd_ptr] : '0;
    assign count_o[v*CW +: CW]      = cnt;
    assign credit_o[v]              = credit_q;
  end

  assign read_valid_o = valid;
  assign full_o       = full;
  assign error_o      = err_q;

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Scoreboard bench for noc_vc_input_port: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_noc_vc_input_port;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 5;
  localparam int unsigned NUM_VC = 2;
  localparam int unsigned VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [WIDTH-1:0]        data_i;
  logic [VCW-1:0]          vc_i;
  logic                    write_en;
  logic [NUM_VC-1:0]       shift;
  logic [NUM_VC*WIDTH-1:0] data_o;
  logic [NUM_VC-1:0]       read_valid_o;
  logic [NUM_VC-1:0]       full_o;
  logic [NUM_VC*CW-1:0]    count_o;
  logic [NUM_VC-1:0]       credit_o;
  logic                    error_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: contents of each VC, popped flits awaiting credit.
  logic [WIDTH-1:0]  mq    [NUM_VC][$];
  logic [WIDTH-1:0]  exp_q [NUM_VC][$];
  bit                m_err = 1'b0;
  bit [NUM_VC-1:0]   m_credit = '0;
  logic [WIDTH-1:0]  prev_head [NUM_VC];

  noc_vc_input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .vc_i         (vc_i),
    .write_en     (write_en),
    .shift        (shift),
    .data_o       (data_o),
    .read_valid_o (read_valid_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .credit_o     (credit_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pops take the head, a push fits if there is room or the
  // same VC is popping, and any rejected access sets the sticky error.
  always @(posedge clk or negedge rst_n) begin
    bit [NUM_VC-1:0] pop;
    bit              do_push;
    int              tv;
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        mq[v].delete();
        exp_q[v].delete();
      end
      m_err    = 1'b0;
      m_credit = '0;
    end else begin
      m_credit = '0;
      do_push  = 1'b0;
      tv       = int'(vc_i);
      for (int v = 0; v < NUM_VC; v++) begin
        pop[v] = shift[v] && (mq[v].size() > 0);
        if (shift[v] && mq[v].size() == 0) m_err = 1'b1;
      end
      if (write_en) begin
        if (tv >= int'(NUM_VC)) m_err = 1'b1;
        else if (mq[tv].size() < int'(DEPTH) || pop[tv]) do_push = 1'b1;
        else m_err = 1'b1;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        if (pop[v]) begin
          exp_q[v].push_back(mq[v].pop_front());
          m_credit[v] = 1'b1;
        end
      end
      if (do_push) mq[tv].push_back(data_i);
    end
  end

  // Monitor: compares outputs with the model mid-cycle; on each credit pulse
  // checks the flit that was at the head during the pop cycle.
  always @(negedge clk) begin
    logic [WIDTH-1:0] hd;
    logic [WIDTH-1:0] e;
    for (int v = 0; v < NUM_VC; v++) begin
      hd = data_o[v*WIDTH +: WIDTH];
      chk($sformatf("count%0d", v), 32'(count_o[v*CW +: CW]), 32'(mq[v].size()));
      chk($sformatf("valid%0d", v), 32'(read_valid_o[v]), 32'(mq[v].size() != 0));
      chk($sformatf("full%0d", v), 32'(full_o[v]), 32'(mq[v].size() == int'(DEPTH)));
      chk($sformatf("head%0d", v), 32'(hd), (mq[v].size() != 0) ? 32'(mq[v][0]) : 32'h0);
      chk($sformatf("credit%0d", v), 32'(credit_o[v]), 32'(m_credit[v]));
      if (credit_o[v]) begin
        if (exp_q[v].size() == 0) begin
          chk($sformatf("unexpected_credit%0d", v), 32'(credit_o[v]), 32'h0);
        end else begin
          e = exp_q[v].pop_front();
          chk($sformatf("popped%0d", v), 32'(prev_head[v]), 32'(e));
        end
      end
      prev_head[v] = hd;
    end
    chk("error", 32'(error_o), 32'(m_err));
  end

  // One clock of stimulus: inputs applied 2 units after a rising edge.
  task automatic step(input bit we, input int vc, input logic [WIDTH-1:0] d,
                      input logic [NUM_VC-1:0] sh);
    write_en = we;
    vc_i     = VCW'(vc);
    data_i   = d;
    shift    = sh;
    @(posedge clk);
    #2;
    write_en = 1'b0;
    shift    = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},   32'(data_o),       32'h0);
    chk({tag, "_valid"},  32'(read_valid_o), 32'h0);
    chk({tag, "_full"},   32'(full_o),       32'h0);
    chk({tag, "_count"},  32'(count_o),      32'h0);
    chk({tag, "_credit"}, 32'(credit_o),     32'h0);
    chk({tag, "_error"},  32'(error_o),      32'h0);
  endtask

  initial begin
    rst_n = 1'b0; write_en = 1'b0; shift = '0; vc_i = '0; data_i = '0;
    for (int v = 0; v < NUM_VC; v++) prev_head[v] = '0;
    @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Fill VC0, overflow, then drain.
    for (int i = 1; i <= 5; i++) step(1'b1, 0, WIDTH'(i), 2'b00);
    chk("fill_full0", 32'(full_o[0]), 32'h1);
    chk("fill_count0", 32'(count_o[0 +: CW]), 32'h5);
    step(1'b1, 0, 16'h0006, 2'b00);
    chk("overflow_error", 32'(error_o), 32'h1);
    chk("overflow_count0", 32'(count_o[0 +: CW]), 32'h5);
    for (int i = 1; i <= 5; i++) begin
      chk("drain_head0", 32'(data_o[0 +: WIDTH]), 32'(i));
      step(1'b0, 0, '0, 2'b01);
      chk("drain_credit0", 32'(credit_o[0]), 32'h1);
    end
    chk("drained_valid0", 32'(read_valid_o[0]), 32'h0);
    chk("drained_data0", 32'(data_o[0 +: WIDTH]), 32'h0);

    // Wrap-around with occupancy held at three.
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, 0, WIDTH'(16'h100 + i), 2'b00);
    for (int i = 0; i < 12; i++) step(1'b1, 0, WIDTH'(16'h200 + i), 2'b01);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_head0", 32'(data_o[0 +: WIDTH]), 32'(16'h200 + 9 + i));
      step(1'b0, 0, '0, 2'b01);
    end
    chk("wrap_count0", 32'(count_o[0 +: CW]), 32'h0);

    // Full VC1 accepts a push together with a pop.
    reset_dut();
    for (int i = 0; i < 5; i++) step(1'b1, 1, WIDTH'(16'hA + i), 2'b00);
    step(1'b1, 1, 16'h000F, 2'b10);
    chk("fullpop_error", 32'(error_o), 32'h0);
    chk("fullpop_count1", 32'(count_o[CW +: CW]), 32'h5);
    chk("fullpop_head1", 32'(data_o[WIDTH +: WIDTH]), 32'hB);
    chk("fullpop_credit1", 32'(credit_o[1]), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 0, '0, 2'b10);
    chk("fullpop_last1", 32'(data_o[WIDTH +: WIDTH]), 32'hF);
    step(1'b0, 0, '0, 2'b10);

    // Push plus shift on an empty VC.
    reset_dut();
    step(1'b1, 0, 16'hAAAA, 2'b01);
    chk("emptypush_error", 32'(error_o), 32'h1);
    chk("emptypush_credit0", 32'(credit_o[0]), 32'h0);
    chk("emptypush_count0", 32'(count_o[0 +: CW]), 32'h1);
    chk("emptypush_data0", 32'(data_o[0 +: WIDTH]), 32'hAAAA);

    // Concurrent drain of both VCs.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, WIDTH'(16'h10 + i), 2'b00);
      step(1'b1, 1, WIDTH'(16'h20 + i), 2'b00);
    end
    for (int i = 0; i < 3; i++) begin
      chk("conc_head0", 32'(data_o[0 +: WIDTH]), 32'(16'h10 + i));
      chk("conc_head1", 32'(data_o[WIDTH +: WIDTH]), 32'(16'h20 + i));
      step(1'b0, 0, '0, 2'b11);
      chk("conc_credit", 32'(credit_o), 32'h3);
    end

    // Asynchronous reset between edges.
    reset_dut();
    step(1'b1, 0, 16'h0123, 2'b00);
    step(1'b1, 1, 16'h0456, 2'b00);
    step(1'b1, 1, 16'h0789, 2'b01);
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if (n % 500 == 499) reset_dut();
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, NUM_VC - 1)),
           WIDTH'($urandom), NUM_VC'($urandom) & NUM_VC'($urandom));
    end

    step(1'b0, 0, '0, 2'b00);
    step(1'b0, 0, '0, 2'b00);
    for (int v = 0; v < NUM_VC; v++) chk($sformatf("pending_credit%0d", v), 32'(exp_q[v].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
